// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_pkg
//  Description : Shared mode codes and mode helpers for the LED pattern
//                sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package led_seq_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 3'd0,
    MODE_SHL    = 3'd1,
    MODE_SHR    = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_CNT    = 3'd4
  } mode_e;

  // Auto-rotation order; IDLE has no successor and stays put.
  function automatic mode_e next_mode(mode_e m);
    case (m)
      MODE_SHL:    return MODE_SHR;
      MODE_SHR:    return MODE_BOUNCE;
      MODE_BOUNCE: return MODE_CNT;
      MODE_CNT:    return MODE_SHL;
      default:     return MODE_IDLE;
    endcase
  endfunction

  // Unused codes 5..7 collapse onto IDLE.
  function automatic mode_e decode_mode(logic [MODE_W-1:0] sel);
    case (sel)
      3'd1:    return MODE_SHL;
      3'd2:    return MODE_SHR;
      3'd3:    return MODE_BOUNCE;
      3'd4:    return MODE_CNT;
      default: return MODE_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_sequencer_if
//  Description : Control/status bundle between the tick source and the LED
//                pattern sequencer. The bright input exists only when
//                LED_DIM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_pattern_sequencer_if #(
  parameter int WIDTH = 8
);

  logic                           tick;
  logic                           load;
  logic [led_seq_pkg::MODE_W-1:0] mode_sel;
  logic                           auto_en;
  logic                           pause;
`ifdef LED_DIM_EN
  logic [3:0]                     bright;
`endif
  logic [WIDTH-1:0]               led;
  logic [led_seq_pkg::MODE_W-1:0] mode;
  logic                           busy;

  // Controller side: issues commands, observes the LED drive.
  modport master (
`ifdef LED_DIM_EN
    output bright,
`endif
    output tick, load, mode_sel, auto_en, pause,
    input  led, mode, busy
  );

  // Sequencer side.
  modport slave (
`ifdef LED_DIM_EN
    input  bright,
`endif
    input  tick, load, mode_sel, auto_en, pause,
    output led, mode, busy
  );

endinterface
`default_nettype wire

// File: rtl/led_pattern_sequencer_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm
//  Description : Brightness stage for the LED path: free-running 4-bit PWM
//                counter, duty compare and one output register. Present only
//                when LED_DIM_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`ifdef LED_DIM_EN
module led_pwm #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             clr,
  input  wire logic [WIDTH-1:0] pattern,
  input  wire logic [3:0]       bright,
  output logic      [WIDTH-1:0] led
);

  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             on_w;

  // Duty compare; full scale (15) is treated as always on.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    on_w      = (pwm_cnt_q < bright) || (bright == 4'hF);
    led_d     = pattern & {WIDTH{on_w}};
  end

  // Counter and gated LED register.
  always_ff @(posedge clk) begin
    if (!clr) begin
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule
`endif
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_sequencer
//  Description : 8-LED pattern controller. Steps walk-left, walk-right,
//                bounce and binary-count patterns on tick, enters modes on a
//                load command and optionally rotates modes after DWELL ticks.
//                Optional macro LED_DIM_EN adds a PWM brightness stage
//                (led_pwm) with one extra cycle of LED latency.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DWELL   = 16,
  parameter int DWELL_W = 5
) (
  input wire logic              clk,
  input wire logic              clr,
  led_pattern_sequencer_if.slave bus
);

  localparam logic               DIR_LEFT   = 1'b0;
  localparam logic               DIR_RIGHT  = 1'b1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  mode_e              mode_q, mode_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WIDTH-1:0]   led_w;
  logic               step_w;

  // Starting pattern for a freshly entered mode.
  function automatic logic [WIDTH-1:0] seed_of(mode_e m);
    logic [WIDTH-1:0] s;
    s = '0;
    if (m == MODE_SHL || m == MODE_BOUNCE) s[0] = 1'b1;
    if (m == MODE_SHR)                     s[WIDTH-1] = 1'b1;
    return s;
  endfunction

  // State register: mode FSM, pattern, bounce direction, dwell counter.
  always_ff @(posedge clk) begin
    if (!clr) begin
      mode_q  <= MODE_IDLE;
      pat_q   <= '0;
      dir_q   <= DIR_LEFT;
      dwell_q <= '0;
    end else begin
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
    end
  end

  // Next state: load beats auto-advance, which beats a normal step.
  always_comb begin
    mode_d  = mode_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    dwell_d = bus.auto_en ? dwell_q : '0;
    step_w  = bus.tick && !bus.pause && (mode_q != MODE_IDLE);

    if (bus.load) begin
      mode_d  = decode_mode(bus.mode_sel);
      pat_d   = seed_of(mode_d);
      dir_d   = DIR_LEFT;
      dwell_d = '0;
    end else if (step_w) begin
      if (bus.auto_en && dwell_q == DWELL_LAST) begin
        mode_d  = next_mode(mode_q);
        pat_d   = seed_of(mode_d);
        dir_d   = DIR_LEFT;
        dwell_d = '0;
      end else begin
        if (bus.auto_en) dwell_d = dwell_q + DWELL_W'(1);
        case (mode_q)
          MODE_SHL: pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
          MODE_SHR: pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
          MODE_BOUNCE: begin
            // Turn around on the endpoint itself so it is shown only once.
            if (dir_q == DIR_LEFT) begin
              if (pat_q[WIDTH-1]) begin
                pat_d = pat_q >> 1;
                dir_d = DIR_RIGHT;
              end else begin
                pat_d = pat_q << 1;
              end
            end else begin
              if (pat_q[0]) begin
                pat_d = pat_q << 1;
                dir_d = DIR_LEFT;
              end else begin
                pat_d = pat_q >> 1;
              end
            end
          end
          MODE_CNT: pat_d = pat_q + WIDTH'(1);
          default:  pat_d = '0;
        endcase
      end
    end
  end

`ifdef LED_DIM_EN
  led_pwm #(
    .WIDTH   (WIDTH)
  ) u_pwm (
    .clk     (clk),
    .clr     (clr),
    .pattern (pat_q),
    .bright  (bus.bright),
    .led     (led_w)
  );
`else
  assign led_w = pat_q;
`endif

  assign bus.led  = led_w;
  assign bus.mode = mode_q;
  assign bus.busy = (mode_q != MODE_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_sequencer
//  Description : Self-checking bench for led_pattern_sequencer (WIDTH=8,
//                DWELL=4), default build without LED_DIM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_pattern_sequencer;

  localparam int W     = 8;
  localparam int DWELL = 4;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  led_pattern_sequencer_if #(.WIDTH(W)) bus ();

  led_pattern_sequencer #(
    .WIDTH   (W),
    .DWELL   (DWELL),
    .DWELL_W (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: mode, position index within the pattern cycle,
  // counter value and number of counted ticks in the current mode.
  int m_mode, m_ph, m_cv, m_dw;

  function automatic int period(int m);
    if (m == 3) return 2 * W - 2;
    return W;
  endfunction

  function automatic logic [W-1:0] model_led();
    int pos;
    case (m_mode)
      1: return W'(1 << m_ph);
      2: return W'(1 << (W - 1 - m_ph));
      3: begin
        pos = (m_ph < W) ? m_ph : (2 * W - 2 - m_ph);
        return W'(1 << pos);
      end
      4: return W'(m_cv);
      default: return '0;
    endcase
  endfunction

  task automatic model_update();
    if (!clr) begin
      m_mode = 0; m_ph = 0; m_cv = 0; m_dw = 0;
    end else if (bus.load) begin
      m_mode = (bus.mode_sel > 3'd4) ? 0 : int'(bus.mode_sel);
      m_ph = 0; m_cv = 0; m_dw = 0;
    end else begin
      if (!bus.auto_en) m_dw = 0;
      if (m_mode != 0 && bus.tick && !bus.pause) begin
        if (bus.auto_en && m_dw == DWELL - 1) begin
          m_mode = (m_mode == 4) ? 1 : m_mode + 1;
          m_ph = 0; m_cv = 0; m_dw = 0;
        end else begin
          if (bus.auto_en) m_dw++;
          m_ph = (m_ph + 1) % period(m_mode);
          m_cv = (m_cv + 1) % (1 << W);
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [W-1:0] l, logic [2:0] md, logic b);
    chk({nm, ".led"}, 32'(bus.led), 32'(l));
    chk({nm, ".mode"}, 32'(bus.mode), 32'(md));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(b));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(logic c, logic ld, logic [2:0] sel, logic tk,
                       logic ae, logic ps);
    clr = c; bus.load = ld; bus.mode_sel = sel;
    bus.tick = tk; bus.auto_en = ae; bus.pause = ps;
  endtask

  task automatic idle_drive(logic ae);
    drive(1'b1, 1'b0, 3'd0, 1'b0, ae, 1'b0);
  endtask

  task automatic do_tick(logic ae);
    drive(1'b1, 1'b0, 3'd0, 1'b1, ae, 1'b0);
    cyc();
  endtask

  task automatic do_load(logic [2:0] sel, logic ae);
    drive(1'b1, 1'b1, sel, 1'b0, ae, 1'b0);
    cyc();
  endtask

  typedef struct {
    logic       clr, load;
    logic [2:0] sel;
    logic       tick, auto_en, pause;
    logic [7:0] e_led;
    logic [2:0] e_mode;
    logic       e_busy;
  } vec_t;

  vec_t       vt[16];
  logic [7:0] bexp[16];

  initial begin
    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    vt[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h01, 3'd1, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h04, 3'd1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h04, 3'd1, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h80, 3'd2, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h40, 3'd2, 1'b1};
    vt[10] = '{1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h01, 3'd3, 1'b1};
    vt[11] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h02, 3'd3, 1'b1};
    vt[12] = '{1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b1};
    vt[13] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h01, 3'd4, 1'b1};
    vt[14] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};

    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

    // Vector table
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].clr, vt[i].load, vt[i].sel, vt[i].tick, vt[i].auto_en,
            vt[i].pause);
      cyc();
      chk_out($sformatf("vec%0d", i), vt[i].e_led, vt[i].e_mode, vt[i].e_busy);
    end

    // Walk left with a tick every 4 clk, wrapping MSB back to 01
    do_load(3'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      idle_drive(1'b0);
      repeat (3) cyc();
      do_tick(1'b0);
      chk($sformatf("shl_t%0d", k), 32'(bus.led), 32'((1 << ((k + 1) % 8)) & 8'hFF));
    end
    chk_out("shl_end", 8'h01, 3'd1, 1'b1);

    // Bounce: endpoints never repeated
    do_load(3'd3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      do_tick(1'b0);
      chk($sformatf("bounce_t%0d", k), 32'(bus.led), 32'(bexp[k]));
    end

    // Counter wrap FE -> FF -> 00
    do_load(3'd4, 1'b0);
    repeat (254) do_tick(1'b0);
    chk("cnt_fe", 32'(bus.led), 32'h0FE);
    do_tick(1'b0);
    chk("cnt_ff", 32'(bus.led), 32'h0FF);
    do_tick(1'b0);
    chk("cnt_wrap", 32'(bus.led), 32'h000);

    // Auto-advance every DWELL ticks through the full rotation
    do_load(3'd1, 1'b1);
    repeat (4) do_tick(1'b1);
    chk_out("auto4", 8'h80, 3'd2, 1'b1);
    repeat (4) do_tick(1'b1);
    chk_out("auto8", 8'h01, 3'd3, 1'b1);
    repeat (4) do_tick(1'b1);
    chk_out("auto12", 8'h00, 3'd4, 1'b1);
    repeat (4) do_tick(1'b1);
    chk_out("auto16", 8'h01, 3'd1, 1'b1);

    // Pause freezes led and dwell; ticks during pause are dropped
    do_load(3'd1, 1'b1);
    repeat (2) do_tick(1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1);
      cyc();
      chk($sformatf("pause_t%0d", k), 32'(bus.led), 32'h04);
    end
    do_tick(1'b1);
    chk_out("pause_rel", 8'h08, 3'd1, 1'b1);
    do_tick(1'b1);
    chk_out("pause_adv", 8'h80, 3'd2, 1'b1);

    // Load together with tick: seed wins and dwell restarts
    drive(1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_out("ldtick", 8'h01, 3'd1, 1'b1);
    repeat (3) do_tick(1'b1);
    chk_out("ldtick_3", 8'h08, 3'd1, 1'b1);
    do_tick(1'b1);
    chk_out("ldtick_4", 8'h80, 3'd2, 1'b1);

    // Reset beats load mid-count
    do_load(3'd4, 1'b0);
    repeat (55) do_tick(1'b0);
    chk("cnt_37", 32'(bus.led), 32'h37);
    drive(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_out("rst_mid", 8'h00, 3'd0, 1'b0);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 600; i++) begin
      clr          = ($urandom_range(0, 39) != 0);
      bus.load     = ($urandom_range(0, 11) == 0);
      bus.mode_sel = 3'($urandom_range(0, 7));
      bus.tick     = ($urandom_range(0, 1) == 1);
      bus.pause    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) bus.auto_en = ~bus.auto_en;
      cyc();
      chk_out($sformatf("rnd%0d", i), model_led(), 3'(m_mode), m_mode != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
